// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control / multi-cycle HI-LO unit: ALUOp classes,
// funct codes, ALU control codes, writeback selects and the mul/div FSM states.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] HILO_ALU = 2'b00;
  localparam logic [1:0] HILO_HI  = 2'b01;
  localparam logic [1:0] HILO_LO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned-magnitude multiplier / restoring divider with sign fix-up.
// One step per cycle while step=1; res_hi/res_lo are the corrected results.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    step,
  input  logic                    is_div,
  input  logic                    is_signed,
  input  logic signed [WIDTH-1:0] rs_val,
  input  logic signed [WIDTH-1:0] rt_val,
  output logic        [WIDTH-1:0] res_hi,
  output logic        [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0] acc, mq, opnd, rs_keep;
  logic             div_q, neg_a, neg_x, dz;

  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   sum, shifted;
  logic             keep;
  logic [WIDTH*2-1:0] prod, prod_s;

  always_comb begin
    rs_neg  = is_signed & rs_val[WIDTH-1];
    rt_neg  = is_signed & rt_val[WIDTH-1];
    rs_mag  = rs_neg ? $unsigned(-rs_val) : $unsigned(rs_val);
    rt_mag  = rt_neg ? $unsigned(-rt_val) : $unsigned(rt_val);
    sum     = {1'b0, acc} + {1'b0, (mq[0] ? opnd : '0)};
    shifted = {acc, mq[WIDTH-1]};
    keep    = shifted >= {1'b0, opnd};
  end

  // Operand latch on accept, then one shift-add / restoring-subtract per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mq      <= '0;
      opnd    <= '0;
      rs_keep <= '0;
      div_q   <= 1'b0;
      neg_a   <= 1'b0;
      neg_x   <= 1'b0;
      dz      <= 1'b0;
    end else if (load) begin
      acc     <= '0;
      mq      <= rs_mag;
      opnd    <= rt_mag;
      rs_keep <= rs_val;
      div_q   <= is_div;
      neg_a   <= rs_neg;
      neg_x   <= rs_neg ^ rt_neg;
      dz      <= (rt_val == '0);
    end else if (step) begin
      if (div_q) begin
        acc <= keep ? WIDTH'(shifted - {1'b0, opnd}) : shifted[WIDTH-1:0];
        mq  <= {mq[WIDTH-2:0], keep};
      end else begin
        acc <= sum[WIDTH:1];
        mq  <= {sum[0], mq[WIDTH-1:1]};
      end
    end
  end

  // Sign correction; divide-by-zero bypasses it so hi returns the raw dividend
  always_comb begin
    prod   = {acc, mq};
    prod_s = neg_x ? -prod : prod;
    if (div_q) begin
      if (dz) begin
        res_lo = '1;
        res_hi = rs_keep;
      end else begin
        res_lo = neg_x ? -mq : mq;
        res_hi = neg_a ? -acc : acc;
      end
    end else begin
      res_hi = prod_s[WIDTH*2-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_control_mc.sv
// ALU control decode plus HI/LO register file with a multi-cycle mul/div FSM.
// Decode is purely combinational; the FSM only governs HI/LO updates and stalls.
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              ALUOp,
  input  logic [5:0]              instruction,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] rs_val,
  input  logic signed [WIDTH-1:0] rt_val,
  output logic [CTRL_W-1:0]       aluControlSignal,
  output logic [1:0]              hilo_sel,
  output logic                    illegal,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        hi,
  output logic [WIDTH-1:0]        lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       alu_code;
  logic             accept, is_md, md_load;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    alu_code = ALU_ADD;
    hilo_sel = HILO_ALU;
    illegal  = 1'b0;
    case (ALUOp)
      ALUOP_ADD: alu_code = ALU_ADD;
      ALUOP_SUB: alu_code = ALU_SUB;
      ALUOP_ORI: alu_code = ALU_OR;
      default: begin
        case (instruction)
          F_ADD:  alu_code = ALU_ADD;
          F_SUB:  alu_code = ALU_SUB;
          F_AND:  alu_code = ALU_AND;
          F_OR:   alu_code = ALU_OR;
          F_NOR:  alu_code = ALU_NOR;
          F_SLT:  alu_code = ALU_SLT;
          F_MFHI: hilo_sel = HILO_HI;
          F_MFLO: hilo_sel = HILO_LO;
          F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: ;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign aluControlSignal = CTRL_W'(alu_code);

  assign accept  = start && (ALUOp == ALUOP_RTYPE) && (state == ST_IDLE);
  assign is_md   = (instruction == F_MULT) || (instruction == F_MULTU) ||
                   (instruction == F_DIV)  || (instruction == F_DIVU);
  assign md_load = accept && is_md;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ST_RUN) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (md_load) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // HI/LO: moves land at the accepting edge, mul/div results at the FIX edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (accept && instruction == F_MTHI) begin
      hi <= rs_val;
    end else if (accept && instruction == F_MTLO) begin
      lo <= rs_val;
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (md_load),
    .step      (state == ST_RUN),
    .is_div    (instruction[1]),
    .is_signed (~instruction[0]),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc at WIDTH=32: decode sweep, mul/div results
// and latency, HI/LO moves, busy-time start rejection and mid-operation reset.
module tb_alu_control_mc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    ALUOp;
  logic [5:0]    instruction;
  logic          start;
  logic [W-1:0]  rs_val, rt_val;
  logic [3:0]    aluControlSignal;
  logic [1:0]    hilo_sel;
  logic          illegal, busy, done;
  logic [W-1:0]  hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_control_mc #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ALUOp            (ALUOp),
    .instruction      (instruction),
    .start            (start),
    .rs_val           (rs_val),
    .rt_val           (rt_val),
    .aluControlSignal (aluControlSignal),
    .hilo_sel         (hilo_sel),
    .illegal          (illegal),
    .busy             (busy),
    .done             (done),
    .hi               (hi),
    .lo               (lo)
  );

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic [1:0] sel;
    logic       ill;
  } dec_t;

  dec_t dec_tab[20] = '{
    '{2'b00, 6'h00, 4'b0010, 2'b00, 1'b0},
    '{2'b01, 6'h00, 4'b0110, 2'b00, 1'b0},
    '{2'b11, 6'h00, 4'b0001, 2'b00, 1'b0},
    '{2'b00, 6'h10, 4'b0010, 2'b00, 1'b0},
    '{2'b10, 6'h20, 4'b0010, 2'b00, 1'b0},
    '{2'b10, 6'h22, 4'b0110, 2'b00, 1'b0},
    '{2'b10, 6'h24, 4'b0000, 2'b00, 1'b0},
    '{2'b10, 6'h25, 4'b0001, 2'b00, 1'b0},
    '{2'b10, 6'h27, 4'b1100, 2'b00, 1'b0},
    '{2'b10, 6'h2A, 4'b0111, 2'b00, 1'b0},
    '{2'b10, 6'h10, 4'b0010, 2'b01, 1'b0},
    '{2'b10, 6'h12, 4'b0010, 2'b10, 1'b0},
    '{2'b10, 6'h11, 4'b0010, 2'b00, 1'b0},
    '{2'b10, 6'h13, 4'b0010, 2'b00, 1'b0},
    '{2'b10, 6'h18, 4'b0010, 2'b00, 1'b0},
    '{2'b10, 6'h19, 4'b0010, 2'b00, 1'b0},
    '{2'b10, 6'h1A, 4'b0010, 2'b00, 1'b0},
    '{2'b10, 6'h1B, 4'b0010, 2'b00, 1'b0},
    '{2'b10, 6'h3F, 4'b0010, 2'b00, 1'b1},
    '{2'b10, 6'h00, 4'b0010, 2'b00, 1'b1}
  };

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept on the next edge, then count cycles (first cycle after accept = 1)
  // until done; done belongs in cycle W+2.
  task automatic run_op(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int n;
    ALUOp = 2'b10; instruction = fn; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, W + 2);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    @(posedge clk); #1;
    check({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int n;
    logic saw_done;
    rst_n = 1'b0; ALUOp = 2'b00; instruction = 6'h00; start = 1'b0;
    rs_val = '0; rt_val = '0;
    #12;
    check("reset_state", {busy, done, hi, lo}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (dec_tab[i]) begin
      ALUOp = dec_tab[i].op; instruction = dec_tab[i].fn;
      #1;
      check($sformatf("dec%0d_code", i), aluControlSignal, dec_tab[i].code);
      check($sformatf("dec%0d_sel", i), hilo_sel, dec_tab[i].sel);
      check($sformatf("dec%0d_ill", i), illegal, dec_tab[i].ill);
    end
    @(posedge clk); #1;

    run_op("multu", 6'h19, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE);
    run_op("mult",  6'h18, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div",   6'h1A, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divmn", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu0", 6'h1B, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF);

    // mthi while busy must not touch hi; decode stays live during the op
    ALUOp = 2'b10; instruction = 6'h18; rs_val = 32'd7; rt_val = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    instruction = 6'h11; rs_val = 32'hAA;
    #1;
    check("busy_decode_ill", illegal, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    check("mthi_busy_hi", hi, 32'h00001234);
    n = 2;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mthi_busy_latency", n, W + 2);
    check("mthi_busy_hi_done", hi, 32'd0);
    check("mthi_busy_lo_done", lo, 32'd42);
    @(posedge clk); #1;

    ALUOp = 2'b10; instruction = 6'h13; rs_val = 32'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_lo", lo, 32'h55);
    check("mtlo_nodone", {busy, done}, 2'b00);
    ALUOp = 2'b10; instruction = 6'h11; rs_val = 32'h77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mthi_hi", hi, 32'h77);

    // Abort a multiply with reset partway through RUN
    ALUOp = 2'b10; instruction = 6'h18; rs_val = 32'd3; rt_val = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    check("rst_mid_nodone", saw_done, 1'b0);
    rst_n = 1'b1;
    run_op("post_rst", 6'h19, 32'h10, 32'h10, 32'h0, 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_control_mc.md
ALU_CONTROL_MC -- requirements
Module: alu_control_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/HI/LO width (even, >= 8).
REQ-002 SHALL have parameter CTRL_W, default 4, the ALU control code width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ALUOp  input  2  class from main control: 00 add, 01 sub, 10 R-type, 11 OR-immediate.
REQ-006 SHALL have port instruction  input  6  funct field.
REQ-007 SHALL have port start  input  1  instruction valid in execute this cycle.
REQ-008 SHALL have port rs_val  input  WIDTH  first operand (multiplicand/dividend/move source).
REQ-009 SHALL have port rt_val  input  WIDTH  second operand (multiplier/divisor).
REQ-010 SHALL have port aluControlSignal  output  CTRL_W  primary ALU code, combinational.
REQ-011 SHALL have port hilo_sel  output  2  writeback select: 00 ALU, 01 HI, 10 LO, combinational.
REQ-012 SHALL have port illegal  output  1  combinational: ALUOp=10 with unlisted funct.
REQ-013 SHALL have ports busy  output  1 (stall request) and done  output  1 (one-cycle completion pulse).
REQ-014 SHALL have ports hi, lo  output  WIDTH  registered HI/LO.

Function
REQ-015 Decode SHALL be: ALUOp 00->0010, 01->0110, 11->0001; ALUOp 10 funct 0x20->0010, 0x22->0110, 0x24->0000, 0x25->0001, 0x27 nor->1100, 0x2A->0111.
REQ-016 ALUOp 10 funct 0x10 mfhi / 0x12 mflo SHALL give hilo_sel 01 / 10; all other cases 00.
REQ-017 Unlisted funct under ALUOp 10 SHALL give aluControlSignal 0010, illegal=1; 0x10-0x13, 0x18-0x1B are listed.
REQ-018 An op is accepted only when start=1, ALUOp=10, FSM in IDLE.
REQ-019 Accepted mthi (0x11) / mtlo (0x13) SHALL load rs_val into hi / lo at that edge; no busy, no done.
REQ-020 Accepted mult 0x18, multu 0x19, div 0x1A, divu 0x1B SHALL latch operands, enter RUN.
REQ-021 FSM states: IDLE -> RUN (WIDTH cycles, one shift-add or restoring-subtract step each) -> FIX (one cycle, sign correction, HI/LO write) -> DONE (one cycle) -> IDLE.
REQ-022 busy SHALL be 1 in RUN, FIX, DONE, else 0.
REQ-023 done SHALL be 1 only in DONE, exactly WIDTH+2 cycles after the accepting edge; hi/lo hold the new result when done=1.
REQ-024 Signed ops SHALL operate on magnitudes; product sign = sign(rs)^sign(rt); quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs).
REQ-025 Multiply: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product.
REQ-026 Divide: lo = quotient, hi = remainder (truncating toward zero).
REQ-027 Divisor 0 SHALL give lo = all ones, hi = rs_val, same latency, no error flag.
REQ-028 Signed div of most-negative by -1 SHALL give lo = most-negative, hi = 0.
REQ-029 start while busy=1 SHALL be ignored (no accept, no mthi/mtlo write); hi/lo hold old values until FIX.
REQ-030 Decode outputs SHALL remain combinational on ALUOp/instruction regardless of FSM state.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0, operand/accumulator registers 0, including mid-operation; aborted op produces no done.
REQ-032 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package alu_ctrl_pkg SHALL hold funct constants, ALUOp constants, ALU control codes, and the FSM state enum.
REQ-034 The iterative datapath (RUN/FIX arithmetic, accumulators) SHALL be sub-module muldiv_iter; alu_control_mc holds decode, FSM, HI/LO.

Verification (WIDTH=32)
REQ-035 Decode sweep: every ALUOp/funct in REQ-015..017 -> listed code, hilo_sel, illegal; funct 0x3F -> 0010, illegal=1.
REQ-036 multu 0xFFFFFFFF x 0x2 -> done 34 cycles after accept, hi=0x00000001, lo=0xFFFFFFFE; mult -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-038 divu 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234, done at 34 cycles.
REQ-039 mthi 0xAA during busy -> ignored, hi = multiply result at done; mtlo 0x55 in IDLE -> lo=0x55 next cycle, no done.
REQ-040 rst_n low at cycle 10 of a mult -> busy=0, hi=lo=0 immediately, no done pulse; new multu accepted after release completes normally.
